store_coalesce_buffer: RTL
==========================

Name: store_coalesce_buffer

Overview:
- Sits directly downstream of the store buffer's commit queue and upstream of the D$ store port.
- Accepts committed, non-speculative stores with a req/gnt handshake and holds them in a small in-order FIFO.
- A new store whose word address matches the youngest queued entry is merged byte-wise into that entry, provided the entry is not currently being offered to the cache.
- Entries drain in order to the D$ with req/gnt; a page-offset checker lets the load unit stall on potential RAW hazards.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >=2).
- PLEN, 56, physical address width.
- XLEN, 64, data width; word = XLEN/8 bytes; WOFF = log2(XLEN/8).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_req_i  in  1  upstream store valid.
- in_gnt_o  out  1  store accepted this cycle (combinational).
- in_addr_i  in  PLEN  physical byte address.
- in_data_i  in  XLEN  store data, already lane-aligned.
- in_be_i  in  XLEN/8  byte enables.
- in_size_i  in  2  access size code.
- out_req_o  out  1  head entry valid toward D$.
- out_gnt_i  in  1  D$ grant for head.
- out_addr_o  out  PLEN  head address, word-aligned (low WOFF bits zero).
- out_data_o  out  XLEN  head data.
- out_be_o  out  XLEN/8  head byte enables.
- out_size_o  out  2  head size code.
- page_offset_i  in  12  load page offset to check.
- page_offset_matches_o  out  1  some valid entry or incoming store matches page_offset_i[11:WOFF].
- empty_o  out  1  FIFO holds no entries.
- merge_cnt_o  out  32  saturating count of merged stores.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous, active-high.
- Reset values:
  - All entries invalid; head, tail and count = 0; merge_cnt_o = 0.
  - out_req_o = 0; empty_o = 1.
  - in_gnt_o and page_offset_matches_o are combinational, so both are 0 while the inputs are idle.
  - Reset mid-operation discards all entries; no D$ request is issued in the cycle after reset.
- Entry fields: word address addr[PLEN-1:WOFF], data, be, size, valid.
- Merge condition (combinational), all of the following must hold:
  - in_req_i = 1;
  - count >= 2;
  - entry[tail-1].valid;
  - entry[tail-1].addr == in_addr_i[PLEN-1:WOFF].
- The head is never a merge target, because out_req_o is asserted whenever the head is valid and its fields must stay stable until granted.
- Pop: if out_req_o && out_gnt_i, then:
  - clear entry[head].valid;
  - head <= head+1 (wraps modulo DEPTH);
  - count decrements.
- Push, taken when in_req_i && in_gnt_o:
  - If merge: for each byte b with in_be_i[b] set, data byte b <= in_data_i byte b. Then be <= be | in_be_i; size <= 2'b11 (full word); count unchanged; merge_cnt_o increments, saturating at 32'hFFFF_FFFF.
  - Else: write all fields into entry[tail]; tail <= tail+1 (wraps); count increments.
- in_gnt_o = in_req_i && (merge || count < DEPTH).
  - When the FIFO is full and the store does not merge, in_gnt_o = 0, even if a pop happens in the same cycle (no fall-through).
- Simultaneous pop and merge with count == 2:
  - The merge target is head+1, which becomes the head next cycle carrying the merged contents.
  - Count next = 1.
- Simultaneous pop and non-merge push: count unchanged.
- Latency: an accepted store is visible on out_req_o in the next cycle at the earliest. There is no combinational in-to-out path.
- Output holding: out_* fields reflect entry[head] and remain stable while out_req_o = 1 && out_gnt_i = 0.
- empty_o = (count == 0).
- page_offset_matches_o = 1 if either of:
  - any valid entry has addr bits [11:WOFF] == page_offset_i[11:WOFF];
  - in_req_i && in_addr_i[11:WOFF] == page_offset_i[11:WOFF].
- Pointer/count widths: head and tail are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.
- Illegal stimulus (flagged by assertions, not handled):
  - in_* changing while in_req_i = 1 && in_gnt_o = 0;
  - out_gnt_i = 1 while out_req_o = 0.

Test Plan:
- Single store: push addr 0x1000, be 0x0F, data 0x11223344. Required response: out_req_o = 1 on the next cycle with addr 0x1000, be 0x0F. Grant it; empty_o = 1 on the following cycle.
- Merge: with out_gnt_i held 0, push 0x2000 (be 0x01), then 0x3000 (be 0x01, data byte 0xAA), then 0x3004 (be 0xF0, data 0x55667788_00000000). Required response: count = 2; entry 1 has be 0xF1, data 0x55667788_000000AA, size 2'b11; merge_cnt_o = 1.
- No merge into head: with count = 1 and head 0x4000 pending, push 0x4001. Required response: a new entry is allocated; count = 2; merge_cnt_o unchanged.
- Full: with out_gnt_i = 0, fill 4 distinct words. Required response: a 5th non-matching store sees in_gnt_o = 0, including when out_gnt_i = 1 in that same cycle. A store matching tail-1 is still granted and merged.
- Wrap and order: push 10 stores to distinct words while granting randomly. Required response: D$ sees all 10 addresses in push order with correct be and data.
- Page offset and reset: queue 0x5A38, apply page_offset_i 0xA3C. Required response: match = 1; with 0xA40, match = 0. Then assert rst_i for 1 cycle mid-drain. Required response: next cycle empty_o = 1, out_req_o = 0, merge_cnt_o = 0.

Source files
------------

// File: rtl/store_coalesce_buffer.sv
// store_coalesce_buffer
//   Small in-order FIFO between the store-buffer commit queue and the D$ store
//   port. A committed store that hits the same word as the youngest queued
//   entry is merged byte-wise into it, except when that entry is the head.
//   The head is always being offered to the cache, so its fields must not move.
//   A page-offset comparator lets the load unit detect possible RAW hazards.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_req_i / in_gnt_o      upstream store handshake (grant is combinational)
//   in_addr_i/data/be/size   store payload (data already lane-aligned)
//   out_req_o / out_gnt_i    D$ handshake for the head entry
//   out_addr/data/be/size    head payload (address word-aligned)
//   page_offset_i            load page offset to compare against
//   page_offset_matches_o    any valid entry or the incoming store hits the offset word
//   empty_o                  no entries held
//   merge_cnt_o              saturating count of merged stores
module store_coalesce_buffer #(
    parameter int DEPTH = 4,
    parameter int PLEN  = 56,
    parameter int XLEN  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_req_i,
    output logic              in_gnt_o,
    input  logic [PLEN-1:0]   in_addr_i,
    input  logic [XLEN-1:0]   in_data_i,
    input  logic [XLEN/8-1:0] in_be_i,
    input  logic [1:0]        in_size_i,
    output logic              out_req_o,
    input  logic              out_gnt_i,
    output logic [PLEN-1:0]   out_addr_o,
    output logic [XLEN-1:0]   out_data_o,
    output logic [XLEN/8-1:0] out_be_o,
    output logic [1:0]        out_size_o,
    input  logic [11:0]       page_offset_i,
    output logic              page_offset_matches_o,
    output logic              empty_o,
    output logic [31:0]       merge_cnt_o
);
    localparam int NB   = XLEN / 8;
    localparam int WOFF = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int AW   = PLEN - WOFF;

    // Entry storage; addresses are kept as word addresses.
    logic [AW-1:0]   addr_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [NB-1:0]   be_mem   [DEPTH];
    logic [1:0]      size_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [PW:0]   count_reg;
    logic [31:0]   merge_cnt_reg;

    logic [PW-1:0]   last_idx;
    logic            merge;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] merged_data;
    logic [DEPTH-1:0] page_hit;
    logic            unused_bits;

    assign last_idx = tail_reg - PW'(1);

    // count >= 2 guarantees tail-1 is not the head, which is the entry on offer.
    assign merge = in_req_i
                && (count_reg >= (PW+1)'(2))
                && valid_reg[last_idx]
                && (addr_mem[last_idx] == in_addr_i[PLEN-1:WOFF]);

    // Full grant is judged on the current count only: a same-cycle pop does not
    // free a slot for the incoming store.
    assign in_gnt_o = in_req_i && (merge || (count_reg < (PW+1)'(DEPTH)));
    assign push     = in_req_i && in_gnt_o;
    assign out_req_o = valid_reg[head_reg];
    assign pop      = out_req_o && out_gnt_i;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_merge_byte
            assign merged_data[gi*8 +: 8] = in_be_i[gi] ? in_data_i[gi*8 +: 8]
                                                        : data_mem[last_idx][gi*8 +: 8];
        end
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_page_hit
            assign page_hit[gi] = valid_reg[gi]
                               && (addr_mem[gi][11-WOFF:0] == page_offset_i[11:WOFF]);
        end
    endgenerate

    assign page_offset_matches_o = (|page_hit)
                                || (in_req_i && (in_addr_i[11:WOFF] == page_offset_i[11:WOFF]));

    assign out_addr_o  = {addr_mem[head_reg], {WOFF{1'b0}}};
    assign out_data_o  = data_mem[head_reg];
    assign out_be_o    = be_mem[head_reg];
    assign out_size_o  = size_mem[head_reg];
    assign empty_o     = (count_reg == '0);
    assign merge_cnt_o = merge_cnt_reg;

    // Sub-word address bits never take part in any comparison.
    assign unused_bits = ^{in_addr_i[WOFF-1:0], page_offset_i[WOFF-1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg     <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            merge_cnt_reg <= '0;
        end else begin
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + 1'b1;
            end
            if (push && merge) begin
                data_mem[last_idx] <= merged_data;
                be_mem[last_idx]   <= be_mem[last_idx] | in_be_i;
                size_mem[last_idx] <= 2'b11;
                if (merge_cnt_reg != 32'hFFFF_FFFF) begin
                    merge_cnt_reg <= merge_cnt_reg + 1'b1;
                end
            end else if (push) begin
                addr_mem[tail_reg]  <= in_addr_i[PLEN-1:WOFF];
                data_mem[tail_reg]  <= in_data_i;
                be_mem[tail_reg]    <= in_be_i;
                size_mem[tail_reg]  <= in_size_i;
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + 1'b1;
            end
            case ({push && !merge, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A stalled upstream store must hold its payload until granted.
    a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (in_req_i && !in_gnt_o) |=> $stable({in_req_i, in_addr_i, in_data_i, in_be_i, in_size_i}));

    // The cache may only grant an offered head.
    a_gnt_with_req: assert property (@(posedge clk_i) disable iff (rst_i)
        !(out_gnt_i && !out_req_o));

endmodule
